// File: rtl/qam16_pkg.sv
// Shared definitions for the QAM16 transmit modulator: constellation levels,
// control states and the Gray-code level mapping.
package qam16_pkg;

  localparam logic signed [2:0] LVL_M3 = 3'sb101;
  localparam logic signed [2:0] LVL_M1 = 3'sb111;
  localparam logic signed [2:0] LVL_P1 = 3'sb001;
  localparam logic signed [2:0] LVL_P3 = 3'sb011;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Adjacent levels differ in one bit so a one-level slicer error costs one bit.
  function automatic logic signed [2:0] gray_map(input logic [1:0] bits);
    logic signed [2:0] lvl;
    case (bits)
      2'b00:   lvl = LVL_M3;
      2'b01:   lvl = LVL_M1;
      2'b11:   lvl = LVL_P1;
      2'b10:   lvl = LVL_P3;
      default: lvl = LVL_M3;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/qam16_gray_map.sv
// Maps one 2-bit Gray-coded symbol half onto a signed constellation level.
module qam16_gray_map
  import qam16_pkg::*;
(
  input  logic              [1:0] bits,
  output logic signed       [2:0] level
);

  // Pure lookup; no state.
  always_comb begin
    level = gray_map(bits);
  end

endmodule

// File: rtl/qam16_modulator.sv
// QAM16 transmit modulator: accepts 4-bit symbols, holds each for SPS carrier
// samples and emits the passband sample I*cos - Q*sin two clken cycles later.
module qam16_modulator
  import qam16_pkg::*;
#(
  parameter int SPS   = 8,
  parameter int CW    = 10,
  parameter int OUT_W = CW + 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic              [3:0] sym_data,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  input  logic signed    [CW-1:0] carrier_sin,
  input  logic signed    [CW-1:0] carrier_cos,
  input  logic                    carrier_valid,
  output logic signed [OUT_W-1:0] mod_out,
  output logic                    mod_valid,
  output logic                    sym_strobe,
  output logic                    sym_underrun
);

  localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int PW    = CW + 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                    state_r;
  logic          [CNT_W-1:0] cnt_r;
  logic                [3:0] sym_reg_r;
  logic                      underrun_r;
  logic signed      [PW-1:0] pi_r;
  logic signed      [PW-1:0] pq_r;
  logic                      v1_r;
  logic                      f1_r;
  logic signed   [OUT_W-1:0] mod_out_r;
  logic                      mod_valid_r;
  logic                      sym_strobe_r;

  logic signed         [2:0] i_lvl_s;
  logic signed         [2:0] q_lvl_s;
  logic signed      [PW-1:0] i_ext_s;
  logic signed      [PW-1:0] q_ext_s;
  logic signed      [PW-1:0] cos_ext_s;
  logic signed      [PW-1:0] sin_ext_s;
  logic signed   [OUT_W-1:0] diff_s;
  logic                      last_s;
  logic                      ready_s;
  logic                      xfer_s;

  qam16_gray_map u_map_i (
    .bits  (sym_reg_r[3:2]),
    .level (i_lvl_s)
  );

  qam16_gray_map u_map_q (
    .bits  (sym_reg_r[1:0]),
    .level (q_lvl_s)
  );

  // Handshake decode and operand sign extension for the mixer.
  always_comb begin
    last_s    = (cnt_r == CNT_LAST);
    ready_s   = 1'b0;
    if (state_r == IDLE) begin
      ready_s = clken;
    end else begin
      ready_s = clken & carrier_valid & last_s;
    end
    xfer_s    = sym_valid & ready_s;
    i_ext_s   = {{(PW - 3){i_lvl_s[2]}}, i_lvl_s};
    q_ext_s   = {{(PW - 3){q_lvl_s[2]}}, q_lvl_s};
    cos_ext_s = {{(PW - CW){carrier_cos[CW-1]}}, carrier_cos};
    sin_ext_s = {{(PW - CW){carrier_sin[CW-1]}}, carrier_sin};
    diff_s    = {{(OUT_W - PW){pi_r[PW-1]}}, pi_r} - {{(OUT_W - PW){pq_r[PW-1]}}, pq_r};
  end

  // Symbol acceptance, per-symbol sample counting and underrun detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      sym_reg_r  <= 4'b0000;
      underrun_r <= 1'b0;
    end else if (clken) begin
      underrun_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (xfer_s) begin
            sym_reg_r <= sym_data;
            cnt_r     <= '0;
            state_r   <= RUN;
          end
        end
        RUN: begin
          if (carrier_valid) begin
            if (last_s) begin
              // A waiting symbol continues the burst without a gap.
              if (xfer_s) begin
                sym_reg_r <= sym_data;
                cnt_r     <= '0;
              end else begin
                state_r    <= IDLE;
                cnt_r      <= '0;
                underrun_r <= 1'b1;
              end
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Two-stage mixer pipeline: products, then difference with valid/strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pi_r         <= '0;
      pq_r         <= '0;
      v1_r         <= 1'b0;
      f1_r         <= 1'b0;
      mod_out_r    <= '0;
      mod_valid_r  <= 1'b0;
      sym_strobe_r <= 1'b0;
    end else if (clken) begin
      pi_r         <= i_ext_s * cos_ext_s;
      pq_r         <= q_ext_s * sin_ext_s;
      v1_r         <= carrier_valid & (state_r == RUN);
      f1_r         <= (cnt_r == '0);
      mod_out_r    <= diff_s;
      mod_valid_r  <= v1_r;
      sym_strobe_r <= v1_r & f1_r;
    end
  end

  assign sym_ready    = ready_s;
  assign mod_out      = mod_out_r;
  assign mod_valid    = mod_valid_r;
  assign sym_strobe   = sym_strobe_r;
  assign sym_underrun = underrun_r;

endmodule

// File: tb/tb_qam16_modulator.sv
// Self-checking bench for qam16_modulator: reference model feeding a
// scoreboard, a table of single-symbol vectors and multi-cycle corner cases.
module tb_qam16_modulator;

  localparam int SPS   = 8;
  localparam int CW    = 10;
  localparam int OUT_W = 14;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    clken;
  logic              [3:0] sym_data;
  logic                    sym_valid;
  logic                    sym_ready;
  logic signed    [CW-1:0] carrier_sin;
  logic signed    [CW-1:0] carrier_cos;
  logic                    carrier_valid;
  logic signed [OUT_W-1:0] mod_out;
  logic                    mod_valid;
  logic                    sym_strobe;
  logic                    sym_underrun;

  qam16_modulator #(.SPS(SPS), .CW(CW), .OUT_W(OUT_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clken         (clken),
    .sym_data      (sym_data),
    .sym_valid     (sym_valid),
    .sym_ready     (sym_ready),
    .carrier_sin   (carrier_sin),
    .carrier_cos   (carrier_cos),
    .carrier_valid (carrier_valid),
    .mod_out       (mod_out),
    .mod_valid     (mod_valid),
    .sym_strobe    (sym_strobe),
    .sym_underrun  (sym_underrun)
  );

  always #5 clk = ~clk;

  typedef struct { int val; bit strb; int stamp; } sb_t;
  typedef struct { logic [3:0] sym; int c; int s; int exp; } vec_t;

  sb_t        sb[$];
  vec_t       vt[7];
  logic [3:0] tx_q[$];
  int         cap_val[$];
  int         cap_k[$];

  int n_checks = 0;
  int n_pass   = 0;
  int kcnt     = 0;
  int m_cnt    = 0;
  bit m_state  = 1'b0;
  bit m_under  = 1'b0;
  bit m_xfer   = 1'b0;
  bit m_rst_edge = 1'b0;
  bit m_ck_edge  = 1'b0;
  bit mon_en   = 1'b0;
  logic [3:0] m_sym = 4'b0000;
  int n_samp = 0, n_strb = 0, n_under = 0, last_val = 0;
  int p_out = 0;
  bit p_v = 1'b0, p_s = 1'b0, p_u = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int lvl(input logic [1:0] b);
    int lvt[4] = '{-3, -1, 3, 1};
    return lvt[b];
  endfunction

  function automatic int exp_val(input logic [3:0] s, input int c, input int sn);
    return lvl(s[3:2]) * c - lvl(s[1:0]) * sn;
  endfunction

  // Reference model, evaluated on each rising edge from the pre-edge inputs.
  initial forever begin
    @(posedge clk);
    m_rst_edge = !reset_n;
    m_ck_edge  = reset_n && clken;
    if (!reset_n) begin
      m_state = 1'b0; m_cnt = 0; m_under = 1'b0; m_xfer = 1'b0;
      sb.delete();
    end else if (clken) begin
      m_xfer  = sym_valid && (m_state == 1'b0 || (carrier_valid && m_cnt == SPS - 1));
      m_under = 1'b0;
      if (m_state == 1'b0) begin
        if (m_xfer) begin m_sym = sym_data; m_cnt = 0; m_state = 1'b1; end
      end else if (carrier_valid) begin
        sb.push_back('{exp_val(m_sym, int'(carrier_cos), int'(carrier_sin)), m_cnt == 0, kcnt});
        if (m_cnt == SPS - 1) begin
          if (m_xfer) begin m_sym = sym_data; m_cnt = 0; end
          else begin m_state = 1'b0; m_cnt = 0; m_under = 1'b1; end
        end else begin
          m_cnt++;
        end
      end
      kcnt++;
    end else begin
      m_xfer = 1'b0;
    end
  end

  // Symbol source: keeps sym_valid up while symbols are queued.
  initial begin
    sym_valid = 1'b0;
    sym_data  = 4'b0000;
    forever begin
      @(posedge clk); #1;
      if (m_xfer && tx_q.size() > 0) void'(tx_q.pop_front());
      sym_valid = (tx_q.size() > 0);
      sym_data  = (tx_q.size() > 0) ? tx_q[0] : 4'b0000;
    end
  end

  // Output monitor on the falling edge.
  initial forever begin
    sb_t e;
    bit  exp_r;
    @(negedge clk);
    if (mon_en) begin
      if (m_rst_edge) begin
        chk("rst_mod_out", int'(mod_out), 0);
        chk("rst_mod_valid", int'(mod_valid), 0);
        chk("rst_sym_strobe", int'(sym_strobe), 0);
        chk("rst_underrun", int'(sym_underrun), 0);
      end else if (m_ck_edge) begin
        chk("sym_underrun", int'(sym_underrun), int'(m_under));
        if (sym_underrun) n_under++;
        if (mod_valid) begin
          n_samp++;
          if (sym_strobe) n_strb++;
          last_val = int'(mod_out);
          cap_val.push_back(last_val);
          cap_k.push_back(kcnt);
          if (sb.size() == 0) begin
            chk("stray_mod_valid", int'(mod_valid), 0);
          end else begin
            e = sb.pop_front();
            chk("mod_out", last_val, e.val);
            chk("sym_strobe", int'(sym_strobe), int'(e.strb));
            chk("latency", kcnt - e.stamp, 2);
          end
        end else if (sb.size() > 0 && sb[0].stamp + 2 <= kcnt) begin
          chk("missing_sample", int'(mod_valid), 1);
          void'(sb.pop_front());
        end
      end else begin
        chk("frozen_mod_out", int'(mod_out), p_out);
        chk("frozen_mod_valid", int'(mod_valid), int'(p_v));
        chk("frozen_sym_strobe", int'(sym_strobe), int'(p_s));
        chk("frozen_underrun", int'(sym_underrun), int'(p_u));
      end
      exp_r = clken && (m_state == 1'b0 || (carrier_valid && m_cnt == SPS - 1));
      chk("sym_ready", int'(sym_ready), int'(exp_r));
      p_out = int'(mod_out); p_v = mod_valid; p_s = sym_strobe; p_u = sym_underrun;
    end
  end

  task automatic wait_idle(input bit rnd, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
      if (rnd) carrier_valid = 1'($urandom_range(0, 1));
      if (tx_q.size() == 0 && m_state == 1'b0 && sb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", budget);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int s0, st0, u0;
    bit hit;
    reset_n = 1'b0; clken = 1'b1; carrier_valid = 1'b0;
    carrier_cos = '0; carrier_sin = '0;
    vt[0] = '{4'b1010,  100,    0,   300};
    vt[1] = '{4'b1000, -512, -512, -3072};
    vt[2] = '{4'b1000, -512,  511,    -3};
    vt[3] = '{4'b0101,   50,  -20,   -70};
    vt[4] = '{4'b1101,  511,  511,  1022};
    vt[5] = '{4'b0011,   -7,  300,  -279};
    vt[6] = '{4'b0110,  511, -512,  1025};

    // Reset with clken high.
    repeat (3) @(posedge clk);
    mon_en = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post_rst_ready", int'(sym_ready), 1);
    chk("post_rst_mod_valid", int'(mod_valid), 0);
    chk("post_rst_mod_out", int'(mod_out), 0);
    chk("post_rst_underrun", int'(sym_underrun), 0);

    // Single symbols with a continuous carrier.
    @(posedge clk); #1;
    carrier_valid = 1'b1;
    foreach (vt[i]) begin
      carrier_cos = CW'(vt[i].c);
      carrier_sin = CW'(vt[i].s);
      s0 = n_samp; st0 = n_strb; u0 = n_under;
      tx_q.push_back(vt[i].sym);
      wait_idle(1'b0, 200);
      chk("vec_value", last_val, vt[i].exp);
      chk("vec_samples", n_samp - s0, SPS);
      chk("vec_strobes", n_strb - st0, 1);
      chk("vec_underrun", n_under - u0, 1);
    end

    // Back-to-back symbols: gapless, one underrun at the very end.
    carrier_cos = CW'(0); carrier_sin = CW'(200);
    cap_val.delete(); cap_k.delete();
    s0 = n_samp; st0 = n_strb; u0 = n_under;
    tx_q.push_back(4'b0000);
    tx_q.push_back(4'b1111);
    wait_idle(1'b0, 200);
    chk("b2b_samples", n_samp - s0, 2 * SPS);
    chk("b2b_strobes", n_strb - st0, 2);
    chk("b2b_underrun", n_under - u0, 1);
    if (cap_val.size() >= 16) begin
      chk("b2b_first", cap_val[0], 600);
      chk("b2b_sym1_last", cap_val[7], 600);
      chk("b2b_sym2_first", cap_val[8], -200);
      chk("b2b_gapless", cap_k[15] - cap_k[0], 15);
    end

    // Random carrier gaps and a clken pause mid-symbol.
    carrier_cos = CW'(100); carrier_sin = CW'(40);
    cap_val.delete(); cap_k.delete();
    s0 = n_samp; st0 = n_strb; u0 = n_under;
    tx_q.push_back(4'b1110);
    tx_q.push_back(4'b0001);
    repeat (12) begin
      @(posedge clk); #1;
      carrier_valid = 1'($urandom_range(0, 1));
    end
    clken = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      carrier_valid = 1'($urandom_range(0, 1));
    end
    clken = 1'b1;
    wait_idle(1'b1, 600);
    chk("gap_samples", n_samp - s0, 2 * SPS);
    chk("gap_strobes", n_strb - st0, 2);
    chk("gap_underrun", n_under - u0, 1);
    if (cap_val.size() >= 16) begin
      chk("gap_first", cap_val[0], -20);
      chk("gap_last", cap_val[15], -260);
    end

    // Reset mid-symbol at cnt == 4.
    carrier_valid = 1'b1;
    carrier_cos = CW'(100); carrier_sin = CW'(0);
    tx_q.push_back(4'b1010);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(posedge clk); #1;
      if (m_state == 1'b1 && m_cnt == 4) hit = 1'b1;
    end
    chk("reach_cnt4", int'(hit), 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_mod_valid", int'(mod_valid), 0);
    chk("midrst_mod_out", int'(mod_out), 0);
    chk("midrst_strobe", int'(sym_strobe), 0);
    chk("midrst_ready", int'(sym_ready), 1);
    @(posedge clk); #1;
    carrier_cos = CW'(0); carrier_sin = CW'(200);
    s0 = n_samp; st0 = n_strb;
    tx_q.push_back(4'b1111);
    wait_idle(1'b0, 200);
    chk("midrst_samples", n_samp - s0, SPS);
    chk("midrst_strobes", n_strb - st0, 1);
    chk("midrst_value", last_val, -200);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
